// File: rtl/irrigacao_pkg.sv
// rtl/irrigacao_pkg.sv - shared level/state encodings and segment patterns
package irrigacao_pkg;

  typedef enum logic [1:0] {
    NIVEL_FALHA   = 2'd0,
    NIVEL_SECO    = 2'd1,
    NIVEL_UMIDO   = 2'd2,
    NIVEL_MOLHADO = 2'd3
  } nivel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WATER = 2'd1,
    HOLD  = 2'd2
  } estado_t;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;

  function automatic logic [6:0] nivel_to_seg(input logic [1:0] n);
    case (nivel_t'(n))
      NIVEL_SECO:    return SEG_0;
      NIVEL_UMIDO:   return SEG_1;
      NIVEL_MOLHADO: return SEG_2;
      default:       return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/debounce_nivel.sv
// rtl/debounce_nivel.sv - per-channel sensor level debouncer
module debounce_nivel #(
  parameter int NUM_BITS     = 2,
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_BITS-1:0] raw,
  output logic [NUM_BITS-1:0] stable
);

  localparam int CNTW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DEBOUNCE_CYC - 1);

  logic [NUM_BITS-1:0] cand;
  logic [CNTW-1:0]     cnt;

  // Any change of raw restarts the count, so short glitches never reach stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand   <= '0;
      cnt    <= '0;
      stable <= '0;
    end else if (raw != cand) begin
      cand <= raw;
      cnt  <= '0;
    end else if (cnt < CNT_LAST) begin
      cnt <= cnt + 1'b1;
    end else begin
      stable <= cand;
    end
  end

endmodule

// File: rtl/irrigacao_multicanal.sv
// rtl/irrigacao_multicanal.sv - multi-channel irrigation: debounce, round-robin pump grant, status display
module irrigacao_multicanal
  import irrigacao_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int NUM_BITS     = 2,
  parameter int DEBOUNCE_CYC = 4,
  parameter int WATER_CYC    = 8,
  parameter int COOLDOWN_CYC = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic [NUM_CH*NUM_BITS-1:0] nivel,
  input  logic [$clog2(NUM_CH)-1:0]  disp_sel,
  output logic [NUM_CH-1:0]          valvula,
  output logic [NUM_CH-1:0]          falha,
  output logic [6:0]                 seg,
  output logic                       ocupado
);

  localparam int CW   = $clog2(NUM_CH);
  localparam int TMAX = (WATER_CYC > COOLDOWN_CYC) ? WATER_CYC : COOLDOWN_CYC;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] T_WATER = TW'(WATER_CYC - 1);
  localparam logic [TW-1:0] T_COOL  = TW'(COOLDOWN_CYC - 1);

  logic [NUM_BITS-1:0] stab [NUM_CH];
  logic [NUM_CH-1:0]   seco;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_deb
    debounce_nivel #(
      .NUM_BITS     (NUM_BITS),
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_deb (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw    (nivel[g*NUM_BITS +: NUM_BITS]),
      .stable (stab[g])
    );
    assign seco[g] = (stab[g] == NUM_BITS'(NIVEL_SECO));
  end

  estado_t       estado;
  logic [CW-1:0] ch;
  logic [CW-1:0] rr_ptr;
  logic [TW-1:0] timer;

  // First dry channel at or after rr_ptr, wrapping around.
  logic          achou;
  logic [CW-1:0] alvo;
  logic [CW:0]   idx;

  always_comb begin
    achou = 1'b0;
    alvo  = '0;
    idx   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = {1'b0, rr_ptr} + (CW+1)'(k);
      if (idx >= (CW+1)'(NUM_CH)) idx = idx - (CW+1)'(NUM_CH);
      if (!achou && seco[idx[CW-1:0]]) begin
        achou = 1'b1;
        alvo  = idx[CW-1:0];
      end
    end
  end

  logic fim_rega;
  assign fim_rega = (timer == '0) || !enable ||
                    (stab[ch] == NUM_BITS'(NIVEL_MOLHADO)) ||
                    (stab[ch] == NUM_BITS'(NIVEL_FALHA));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado  <= IDLE;
      ch      <= '0;
      rr_ptr  <= '0;
      timer   <= '0;
      valvula <= '0;
      ocupado <= 1'b0;
    end else begin
      case (estado)
        IDLE: begin
          if (enable && achou) begin
            ch      <= alvo;
            valvula <= NUM_CH'(1) << alvo;
            timer   <= T_WATER;
            ocupado <= 1'b1;
            estado  <= WATER;
          end else begin
            valvula <= '0;
          end
        end
        WATER: begin
          if (fim_rega) begin
            valvula <= '0;
            timer   <= T_COOL;
            rr_ptr  <= (ch == CW'(NUM_CH - 1)) ? '0 : ch + 1'b1;
            estado  <= HOLD;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        HOLD: begin
          valvula <= '0;
          if (timer == '0) begin
            ocupado <= 1'b0;
            estado  <= IDLE;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: begin
          valvula <= '0;
          ocupado <= 1'b0;
          estado  <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg   <= SEG_BLANK;
      falha <= '0;
    end else begin
      seg <= ({1'b0, disp_sel} < (CW+1)'(NUM_CH)) ? nivel_to_seg(stab[disp_sel]) : SEG_BLANK;
      for (int i = 0; i < NUM_CH; i++) falha[i] <= (stab[i] == NUM_BITS'(NIVEL_FALHA));
    end
  end

endmodule
